// File: rtl/present_cbc_arbiter_if.sv
// Channel and core-side signal bundle of the two-channel PRESENT CBC arbiter.
// master = arbiter side, slave = front-ends plus encrypt core.
interface present_cbc_arbiter_if #(
  parameter int BLK_W = 64,
  parameter int KEY_W = 80
);
  logic             ch0_start;
  logic [BLK_W-1:0] ch0_iv;
  logic [KEY_W-1:0] ch0_key;
  logic             ch0_valid;
  logic [BLK_W-1:0] ch0_pt;
  logic             ch0_ready;
  logic             ch0_ct_valid;
  logic [BLK_W-1:0] ch0_ct;
  logic             ch0_err;

  logic             ch1_start;
  logic [BLK_W-1:0] ch1_iv;
  logic [KEY_W-1:0] ch1_key;
  logic             ch1_valid;
  logic [BLK_W-1:0] ch1_pt;
  logic             ch1_ready;
  logic             ch1_ct_valid;
  logic [BLK_W-1:0] ch1_ct;
  logic             ch1_err;

  logic             core_load;
  logic             core_load_IV;
  logic [BLK_W-1:0] core_IV;
  logic [BLK_W-1:0] core_plaintext;
  logic [KEY_W-1:0] core_key;
  logic             core_done;
  logic [BLK_W-1:0] core_ciphertext;

  modport master (
    input  ch0_start, ch0_iv, ch0_key, ch0_valid, ch0_pt,
    input  ch1_start, ch1_iv, ch1_key, ch1_valid, ch1_pt,
    input  core_done, core_ciphertext,
    output ch0_ready, ch0_ct_valid, ch0_ct, ch0_err,
    output ch1_ready, ch1_ct_valid, ch1_ct, ch1_err,
    output core_load, core_load_IV, core_IV, core_plaintext, core_key
  );

  modport slave (
    output ch0_start, ch0_iv, ch0_key, ch0_valid, ch0_pt,
    output ch1_start, ch1_iv, ch1_key, ch1_valid, ch1_pt,
    output core_done, core_ciphertext,
    input  ch0_ready, ch0_ct_valid, ch0_ct, ch0_err,
    input  ch1_ready, ch1_ct_valid, ch1_ct, ch1_err,
    input  core_load, core_load_IV, core_IV, core_plaintext, core_key
  );
endinterface

// File: rtl/present_cbc_arbiter.sv
// Time-shares one PRESENT encrypt core between two CBC channels, keeping a
// key / chain value / need-IV flag per channel and round-robin arbitrating blocks.
module present_cbc_arbiter #(
  parameter int BLK_W   = 64,
  parameter int KEY_W   = 80,
  parameter int TIMEOUT = 64
) (
  input logic                   clk,
  input logic                   reset,
  present_cbc_arbiter_if.master bus
);
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [BLK_W-1:0] r_chain [2];
  logic [KEY_W-1:0] r_key   [2];
  logic [BLK_W-1:0] r_ct    [2];
  logic [1:0]       r_need_iv;
  logic             r_last_grant;
  logic             r_owner;
  logic             r_prev_owner;
  logic [BLK_W-1:0] r_pt;
  logic [CNT_W-1:0] r_cnt;

  logic [1:0]       w_start;
  logic [1:0]       w_valid;
  logic [1:0]       w_ready;
  logic [1:0]       w_illegal;
  logic [1:0]       w_ct_valid;
  logic [1:0]       w_tmo_err;
  logic [1:0]       w_err;
  logic [BLK_W-1:0] w_iv [2];
  logic [BLK_W-1:0] w_pt [2];
  logic [KEY_W-1:0] w_key [2];
  logic             w_grant;
  logic             w_accept;
  logic             w_timeout;
  logic             w_load;
  logic             w_busy;

  assign w_start  = {bus.ch1_start, bus.ch0_start};
  assign w_valid  = {bus.ch1_valid, bus.ch0_valid};
  assign w_iv[0]  = bus.ch0_iv;
  assign w_iv[1]  = bus.ch1_iv;
  assign w_key[0] = bus.ch0_key;
  assign w_key[1] = bus.ch1_key;
  assign w_pt[0]  = bus.ch0_pt;
  assign w_pt[1]  = bus.ch1_pt;

  // Sole requester wins; on contention the channel not served last time wins.
  always_comb begin
    w_grant = 1'b0;
    if (w_valid == 2'b11) w_grant = ~r_last_grant;
    else if (w_valid[1])  w_grant = 1'b1;
  end

  assign w_busy    = (r_state != S_IDLE);
  assign w_accept  = (r_state == S_IDLE) && (w_valid != 2'b00) && !reset;
  assign w_timeout = (r_state == S_WAIT) && !bus.core_done &&
                     (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_load    = (r_state == S_LOAD) && !reset;

  always_comb begin
    w_illegal[0] = w_start[0] && w_busy && (r_owner == 1'b0) && !reset;
    w_illegal[1] = w_start[1] && w_busy && (r_owner == 1'b1) && !reset;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 2'b00;
    w_ct_valid  = 2'b00;
    w_tmo_err   = 2'b00;
    if (!reset) begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            w_ready[w_grant] = 1'b1;
            w_state_nxt      = S_LOAD;
          end
        end
        S_LOAD: w_state_nxt = S_WAIT;
        S_WAIT: begin
          if (bus.core_done) begin
            w_state_nxt = S_DONE;
          end else if (w_timeout) begin
            w_tmo_err[r_owner] = 1'b1;
            w_state_nxt        = S_IDLE;
          end
        end
        S_DONE: begin
          w_ct_valid[r_owner] = 1'b1;
          w_state_nxt         = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign w_err = w_illegal | w_tmo_err;

  assign bus.ch0_ready    = w_ready[0];
  assign bus.ch1_ready    = w_ready[1];
  assign bus.ch0_ct_valid = w_ct_valid[0];
  assign bus.ch1_ct_valid = w_ct_valid[1];
  assign bus.ch0_err      = w_err[0];
  assign bus.ch1_err      = w_err[1];
  assign bus.ch0_ct       = r_ct[0];
  assign bus.ch1_ct       = r_ct[1];

  // The core keeps its own chain between blocks of one channel; any switch
  // or a fresh/aborted context forces the chain to be reloaded.
  assign bus.core_load      = w_load;
  assign bus.core_load_IV   = w_load && (r_need_iv[r_owner] || (r_owner != r_prev_owner));
  assign bus.core_IV        = w_load ? r_chain[r_owner] : '0;
  assign bus.core_plaintext = w_load ? r_pt : '0;
  assign bus.core_key       = w_load ? r_key[r_owner] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_chain[0]   <= '0;
      r_chain[1]   <= '0;
      r_key[0]     <= '0;
      r_key[1]     <= '0;
      r_ct[0]      <= '0;
      r_ct[1]      <= '0;
      r_need_iv    <= 2'b11;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_prev_owner <= 1'b0;
      r_pt         <= '0;
      r_cnt        <= '0;
    end else begin
      r_state <= w_state_nxt;
      // New message context lands before any same-cycle block is loaded.
      for (int n = 0; n < 2; n++) begin
        if (w_start[n] && !w_illegal[n]) begin
          r_chain[n]   <= w_iv[n];
          r_key[n]     <= w_key[n];
          r_need_iv[n] <= 1'b1;
        end
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_pt         <= w_pt[w_grant];
            r_owner      <= w_grant;
            r_last_grant <= w_grant;
            r_cnt        <= '0;
          end
        end
        S_LOAD: begin
          r_need_iv[r_owner] <= 1'b0;
          r_prev_owner       <= r_owner;
          r_cnt              <= '0;
        end
        S_WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (bus.core_done)  r_ct[r_owner] <= bus.core_ciphertext;
          else if (w_timeout) r_need_iv     <= 2'b11;
        end
        S_DONE: r_chain[r_owner] <= r_ct[r_owner];
        default: ;
      endcase
    end
  end
endmodule
